// File: rtl/cv32e40p_obi_instr_responder.sv
// rtl/cv32e40p_obi_instr_responder.sv - OBI instruction-fetch responder over a synchronous SRAM
// In-order responses through a stage register plus fall-through FIFO, with optional LFSR throttling.
module cv32e40p_obi_instr_responder #(
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
    parameter int unsigned MEM_WORDS       = 4096,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_en_i,
    input  logic                         obi_req_i,
    output logic                         obi_gnt_o,
    input  logic [31:0]                  obi_addr_i,
    output logic                         obi_rvalid_o,
    output logic [31:0]                  obi_rdata_o,
    output logic                         obi_err_o,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i,
    output logic                         busy_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [32:0]   WIN_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);

    logic [15:0]   r_lfsr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fcnt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_stg_vld;
    logic          r_stg_err;
    logic [31:0]   r_fifo_data [MAX_OUTSTANDING];
    logic          r_fifo_err  [MAX_OUTSTANDING];

    logic          w_gnt_stall;
    logic          w_rsp_stall;
    logic [32:0]   w_off;
    logic          w_in_range;
    logic          w_accept;
    logic          w_fifo_empty;
    logic [31:0]   w_stg_data;
    logic [31:0]   w_src_data;
    logic          w_src_err;
    logic          w_push;
    logic          w_pop;

    assign w_gnt_stall = stall_en_i & r_lfsr[0];
    assign w_rsp_stall = stall_en_i & r_lfsr[1];

    // 33-bit subtraction: bit 32 set means the address lies below the window.
    assign w_off      = {1'b0, obi_addr_i} - {1'b0, MEM_BASE};
    assign w_in_range = !w_off[32] && (w_off < WIN_BYTES);

    // rst_n gates grant so nothing is accepted while reset is held.
    assign obi_gnt_o  = obi_req_i & rst_n & (r_cnt < CNT_MAX) & !w_gnt_stall;
    assign w_accept   = obi_req_i & obi_gnt_o;
    assign mem_req_o  = w_accept & w_in_range;
    assign mem_addr_o = w_off[2 +: AW];

    assign w_fifo_empty = (r_fcnt == '0);
    assign w_stg_data   = r_stg_err ? 32'h0 : mem_rdata_i;
    assign w_src_data   = w_fifo_empty ? w_stg_data : r_fifo_data[r_rd_ptr];
    assign w_src_err    = w_fifo_empty ? r_stg_err  : r_fifo_err[r_rd_ptr];

    assign obi_rvalid_o = (!w_fifo_empty | r_stg_vld) & !w_rsp_stall;
    assign obi_rdata_o  = obi_rvalid_o ? w_src_data : 32'h0;
    assign obi_err_o    = obi_rvalid_o & w_src_err;
    assign busy_o       = (r_cnt != '0);

    assign w_pop  = obi_rvalid_o & !w_fifo_empty;
    assign w_push = r_stg_vld & !(obi_rvalid_o & w_fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (stall_en_i) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_stg_vld <= 1'b0;
            r_stg_err <= 1'b0;
        end else begin
            r_stg_vld <= w_accept;
            r_stg_err <= w_accept & !w_in_range;
            unique case ({w_accept, obi_rvalid_o})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CW'(1);
                2'b01:   r_fcnt <= r_fcnt - CW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_stg_data;
            r_fifo_err[r_wr_ptr]  <= r_stg_err;
        end
    end
endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// tb/tb_cv32e40p_obi_instr_responder.sv - scoreboard bench for the OBI instruction responder
module tb_cv32e40p_obi_instr_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_en = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        gnt, rvalid, err, mem_req, busy;
    logic [31:0] rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem [4096];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    bit          max1_mode = 1'b0;
    logic [15:0] m_lfsr;

    cv32e40p_obi_instr_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_en_i   (stall_en),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_rvalid_o (rvalid),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else if (stall_en) m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input int c, input bit lc);
        exp_t e;
        e.acc_cyc = c;
        e.lat_chk = lc;
        if (a < 32'h4000) begin
            e.data = 32'h1000_0000 + {2'b00, a[31:2]};
            e.err  = 1'b0;
        end else begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every response and checks invariants.
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        if (!rst_n) begin
            m_cnt = 0;
            q.delete();
        end else begin
            acc = req && gnt;
            if (stall_en && m_lfsr[0]) chk("gnt_under_lfsr0", {31'b0, gnt}, 32'd0);
            if (stall_en && m_lfsr[1]) chk("rvalid_under_lfsr1", {31'b0, rvalid}, 32'd0);
            if (m_cnt == 2) chk("gnt_at_limit", {31'b0, gnt}, 32'd0);
            if (max1_mode) chk("cnt_le1", m_cnt, (m_cnt <= 1) ? m_cnt : 1);
            chk("busy", {31'b0, busy}, (m_cnt != 0) ? 32'd1 : 32'd0);
            if (acc) begin
                chk("mem_req_on_accept", {31'b0, mem_req}, (addr < 32'h4000) ? 32'd1 : 32'd0);
                if (addr < 32'h4000) chk("mem_addr", {20'b0, mem_addr}, {20'b0, addr[13:2]});
            end else begin
                chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
            end
            if (rvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("err", {31'b0, err}, {31'b0, e.err});
                    if (e.lat_chk) chk("latency", cyc - e.acc_cyc, 32'd1);
                end
            end else begin
                chk("rdata_idle", rdata, 32'd0);
                chk("err_idle", {31'b0, err}, 32'd0);
            end
            m_cnt = m_cnt + (acc ? 1 : 0) - (rvalid ? 1 : 0);
        end
    end

    task automatic issue(input logic [31:0] a, input bit lc, output int acc_c);
        bit done = 1'b0;
        acc_c = -1;
        req  = 1'b1;
        addr = a;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (gnt) begin
                q.push_back(model(a, cyc, lc));
                acc_c = cyc;
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done = 1'b0;
        req = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !busy) done = 1'b1;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, c0, tmp;
        bit hit;
        for (int k = 0; k < 4096; k++) mem[k] = 32'h1000_0000 + k;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {31'b0, gnt}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back fetch
        max1_mode = 1'b1;
        c0 = cyc;
        issue(32'h0, 1'b1, a0);
        issue(32'h4, 1'b1, a1);
        issue(32'h8, 1'b1, a2);
        chk("b2b_gnt0", a0, c0);
        chk("b2b_gnt1", a1, c0 + 1);
        chk("b2b_gnt2", a2, c0 + 2);
        drain();
        max1_mode = 1'b0;

        // Out of range then in range
        issue(32'h4000, 1'b1, tmp);
        issue(32'h10, 1'b1, tmp);
        issue(32'hFFFF_FFFC, 1'b1, tmp);
        drain();

        // Misaligned address
        issue(32'h6, 1'b1, tmp);
        drain();

        // Throttled random traffic
        stall_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            issue({18'b0, 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3))}, 1'b0, tmp);
        end
        drain();

        // Build up two outstanding, then reset mid-operation
        hit  = 1'b0;
        req  = 1'b1;
        addr = 32'hC;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (gnt) q.push_back(model(addr, cyc, 1'b0));
            #1;
            if (m_cnt == 2) hit = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("reached_cnt2", {31'b0, hit}, 32'd1);
        chk("busy_at_cnt2", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", {31'b0, gnt}, 32'd0);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        req      = 1'b0;
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'h8, 1'b1, tmp);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
